// File: rtl/prim_cipher_pkg.sv
// Shared types and helpers for the counter-mode keystream generator around a PRINCE core.
package prim_cipher_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } ctr_gen_state_e;

  function automatic int unsigned ctr_width(input int unsigned data_width,
                                            input int unsigned nonce_width);
    return data_width - nonce_width;
  endfunction

endpackage

// File: rtl/prim_fifo_sync.sv
// Synchronous FIFO with registered storage and no pass-through; clr_i flushes all entries.
module prim_fifo_sync #(
  parameter int unsigned Width = 64,
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             wvalid_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             rready_i,
  output logic             rvalid_o,
  output logic [Width-1:0] rdata_o,
  output logic [CntW-1:0]  count_o
);

  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [CntW-1:0]  count_q;
  logic [Width-1:0] mem_q [Depth];
  logic             full, push, pop;

  assign full     = (count_q == CntW'(Depth));
  assign rvalid_o = (count_q != '0);
  assign pop      = rready_i & rvalid_o;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign push     = wvalid_i & (~full | pop);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (clr_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + PtrW'(1);
      if (pop)  rptr_q <= rptr_q + PtrW'(1);
      if (push && !pop)      count_q <= count_q + CntW'(1);
      else if (pop && !push) count_q <= count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push && !clr_i) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = rvalid_o ? mem_q[rptr_q] : '0;
  assign count_o = count_q;

endmodule

// File: rtl/prim_prince_ctr_gen.sv
// Counter-mode keystream generator: issues {nonce, ctr} blocks to a PRINCE core under credit
// control and buffers the in-order responses for a ready/valid consumer.
module prim_prince_ctr_gen
  import prim_cipher_pkg::*;
#(
  parameter int unsigned DataWidth  = 64,
  parameter int unsigned KeyWidth   = 128,
  parameter int unsigned NonceWidth = 32,
  parameter int unsigned FifoDepth  = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  init_i,
  input  logic [NonceWidth-1:0] nonce_i,
  input  logic [KeyWidth-1:0]   key_i,
  output logic                  cipher_valid_o,
  output logic [DataWidth-1:0]  cipher_data_o,
  output logic [KeyWidth-1:0]   cipher_key_o,
  output logic                  cipher_dec_o,
  input  logic                  cipher_valid_i,
  input  logic [DataWidth-1:0]  cipher_data_i,
  output logic                  ks_valid_o,
  input  logic                  ks_ready_i,
  output logic [DataWidth-1:0]  ks_data_o,
  output logic                  busy_o,
  output logic                  exhausted_o
);

  localparam int unsigned CtrW = ctr_width(DataWidth, NonceWidth);
  localparam int unsigned CntW = $clog2(FifoDepth) + 1;
  localparam logic [CntW:0] DepthVal = FifoDepth[CntW:0];

  if (!((DataWidth == 64 || DataWidth == 32) && KeyWidth == 2 * DataWidth)) begin : gen_bad_width
    $fatal(1, "DataWidth must be 32 or 64 and KeyWidth must be 2*DataWidth");
  end
  if (!(FifoDepth >= 2 && (FifoDepth & (FifoDepth - 1)) == 0)) begin : gen_bad_depth
    $fatal(1, "FifoDepth must be a power of two and at least 2");
  end
  if (!(NonceWidth + 2 <= DataWidth)) begin : gen_bad_ctr
    $fatal(1, "counter width DataWidth-NonceWidth must be at least 2");
  end

  ctr_gen_state_e        state_q, state_d;
  logic [CtrW-1:0]       ctr_q, ctr_d;
  logic [NonceWidth-1:0] nonce_q;
  logic [KeyWidth-1:0]   key_q;
  logic [CntW-1:0]       inflight_q, inflight_d;
  logic [CntW-1:0]       discard_q, discard_d;
  logic [CntW-1:0]       fifo_count;
  logic [CntW:0]         credit_used;
  logic                  issue, resp, ctr_last, fifo_push;

  assign credit_used = {1'b0, inflight_q} + {1'b0, fifo_count};
  assign issue       = (state_q == StRun) && (credit_used < DepthVal);
  // Responses with nothing outstanding are strays from before a reset.
  assign resp        = cipher_valid_i && (inflight_q != '0);
  assign ctr_last    = &ctr_q;
  assign fifo_push   = resp && (discard_q == '0) && !init_i;

  always_comb begin
    state_d    = state_q;
    ctr_d      = ctr_q;
    inflight_d = inflight_q;
    discard_d  = discard_q;

    if (issue && !resp)      inflight_d = inflight_q + CntW'(1);
    else if (resp && !issue) inflight_d = inflight_q - CntW'(1);

    if (resp && discard_q != '0) discard_d = discard_q - CntW'(1);
    if (issue && !ctr_last)      ctr_d     = ctr_q + CtrW'(1);

    unique case (state_q)
      StIdle:  state_d = StIdle;
      StRun:   if (issue && ctr_last) state_d = StDone;
      StDone:  state_d = StDone;
      default: state_d = StIdle;
    endcase

    // Everything still outstanding after this cycle, including a request issued now, is stale.
    if (init_i) begin
      state_d   = StRun;
      ctr_d     = '0;
      discard_d = inflight_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      ctr_q      <= '0;
      nonce_q    <= '0;
      key_q      <= '0;
      inflight_q <= '0;
      discard_q  <= '0;
    end else begin
      state_q    <= state_d;
      ctr_q      <= ctr_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
      if (init_i) begin
        nonce_q <= nonce_i;
        key_q   <= key_i;
      end
    end
  end

  prim_fifo_sync #(
    .Width (DataWidth),
    .Depth (FifoDepth)
  ) u_ks_fifo (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (init_i),
    .wvalid_i (fifo_push),
    .wdata_i  (cipher_data_i),
    .rready_i (ks_ready_i),
    .rvalid_o (ks_valid_o),
    .rdata_o  (ks_data_o),
    .count_o  (fifo_count)
  );

  assign cipher_valid_o = issue;
  assign cipher_data_o  = {nonce_q, ctr_q};
  assign cipher_key_o   = key_q;
  assign cipher_dec_o   = 1'b0;
  assign busy_o         = (state_q == StRun) || (inflight_q != '0) || (discard_q != '0);
  assign exhausted_o    = (state_q == StDone) && (inflight_q == '0) && (fifo_count == '0);

endmodule

// File: tb/tb_prim_prince_ctr_gen.sv
// Directed bench for prim_prince_ctr_gen: basic run, backpressure, reset, re-init, exhaustion.
module tb_prim_prince_ctr_gen;

  localparam logic [127:0] Key1 = 128'h0011_2233_4455_6677_8899_aabb_ccdd_eeff;
  localparam logic [127:0] Key2 = 128'hfedc_ba98_7654_3210_0f1e_2d3c_4b5a_6978;
  localparam logic [127:0] Key3 = 128'h1357_9bdf_0246_8ace_f0e1_d2c3_b4a5_9687;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Instance A: default parameters.
  logic         a_init, a_cv_o, a_dec, a_cv_i, a_ksv, a_ksr, a_busy, a_exh;
  logic [31:0]  a_nonce;
  logic [127:0] a_key, a_ck_o;
  logic [63:0]  a_cd_o, a_cd_i, a_ksd;
  logic [1:0]   a_sel;

  // Instance B: 4-bit counter.
  logic         b_init, b_cv_o, b_dec, b_cv_i, b_ksv, b_ksr, b_busy, b_exh;
  logic [59:0]  b_nonce;
  logic [127:0] b_key, b_ck_o;
  logic [63:0]  b_cd_o, b_cd_i, b_ksd;

  prim_prince_ctr_gen dut_a (
    .clk_i          (clk),
    .rst_i          (rst),
    .init_i         (a_init),
    .nonce_i        (a_nonce),
    .key_i          (a_key),
    .cipher_valid_o (a_cv_o),
    .cipher_data_o  (a_cd_o),
    .cipher_key_o   (a_ck_o),
    .cipher_dec_o   (a_dec),
    .cipher_valid_i (a_cv_i),
    .cipher_data_i  (a_cd_i),
    .ks_valid_o     (a_ksv),
    .ks_ready_i     (a_ksr),
    .ks_data_o      (a_ksd),
    .busy_o         (a_busy),
    .exhausted_o    (a_exh)
  );

  prim_prince_ctr_gen #(
    .NonceWidth (60)
  ) dut_b (
    .clk_i          (clk),
    .rst_i          (rst),
    .init_i         (b_init),
    .nonce_i        (b_nonce),
    .key_i          (b_key),
    .cipher_valid_o (b_cv_o),
    .cipher_data_o  (b_cd_o),
    .cipher_key_o   (b_ck_o),
    .cipher_dec_o   (b_dec),
    .cipher_valid_i (b_cv_i),
    .cipher_data_i  (b_cd_i),
    .ks_valid_o     (b_ksv),
    .ks_ready_i     (b_ksr),
    .ks_data_o      (b_ksd),
    .busy_o         (b_busy),
    .exhausted_o    (b_exh)
  );

  // Stand-in for the PRINCE core: any fixed keyed bijection serves for ordering checks.
  function automatic logic [63:0] prince_model(input logic [63:0] d, input logic [127:0] k);
    return {d[40:0], d[63:41]} ^ k[63:0] ^ {k[95:64], k[127:96]} ^ 64'h0123_4567_89ab_cdef;
  endfunction

  logic [2:0]  a_pv;
  logic [63:0] a_pd [3];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      a_pv <= '0;
    end else begin
      a_pv    <= {a_pv[1:0], a_cv_o};
      a_pd[0] <= prince_model(a_cd_o, a_ck_o);
      a_pd[1] <= a_pd[0];
      a_pd[2] <= a_pd[1];
    end
  end
  assign a_cv_i = a_pv[a_sel];
  assign a_cd_i = a_pd[a_sel];

  logic        b_pv;
  logic [63:0] b_pd;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      b_pv <= 1'b0;
    end else begin
      b_pv <= b_cv_o;
      b_pd <= prince_model(b_cd_o, b_ck_o);
    end
  end
  assign b_cv_i = b_pv;
  assign b_cd_i = b_pd;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int n, words, reqs;
    bit seen;
    rst = 1'b1;
    a_init = 1'b0; a_nonce = '0; a_key = '0; a_ksr = 1'b0; a_sel = 2'd0;
    b_init = 1'b0; b_nonce = '0; b_key = '0; b_ksr = 1'b0;
    repeat (2) @(negedge clk);

    check_eq("rst_cv", a_cv_o, 0);
    check_eq("rst_ksv", a_ksv, 0);
    check_eq("rst_busy", a_busy, 0);
    check_eq("rst_exh", a_exh, 0);
    check_eq("rst_cd", a_cd_o, 0);
    check_eq("rst_ck", a_ck_o, 0);
    check_eq("rst_ksd", a_ksd, 0);
    check_eq("rst_b_exh", b_exh, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("idle_cv", a_cv_o, 0);

    // Basic run, 1-cycle cipher.
    a_nonce = 32'hA5A5_A5A5; a_key = Key1; a_ksr = 1'b1; a_init = 1'b1;
    @(negedge clk);
    a_init = 1'b0;
    check_eq("run_key", a_ck_o, Key1);
    check_eq("run_dec", a_dec, 0);
    for (int i = 0; i < 10; i++) begin
      check_eq("run_req_v", a_cv_o, 1);
      check_eq("run_req_d", a_cd_o, {32'hA5A5_A5A5, 32'(i)});
      if (i >= 2) begin
        check_eq("run_ks_v", a_ksv, 1);
        check_eq("run_ks_d", a_ksd, prince_model({32'hA5A5_A5A5, 32'(i - 2)}, Key1));
      end else begin
        check_eq("run_ks_v0", a_ksv, 0);
      end
      @(negedge clk);
    end

    // Backpressure: the credit limit stops issue at FifoDepth outstanding words.
    reset_pulse();
    a_ksr = 1'b0; a_nonce = 32'h1234_5678; a_key = Key2; a_init = 1'b1;
    @(negedge clk);
    a_init = 1'b0;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      if (a_cv_o) n++;
      @(negedge clk);
    end
    check_eq("bp_issued", n, 4);
    check_eq("bp_ksv", a_ksv, 1);
    check_eq("bp_head0", a_ksd, prince_model({32'h1234_5678, 32'd0}, Key2));
    a_ksr = 1'b1;
    @(negedge clk);
    a_ksr = 1'b0;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (a_cv_o) n++;
      @(negedge clk);
    end
    check_eq("bp_one_more", n, 1);
    check_eq("bp_head1", a_ksd, prince_model({32'h1234_5678, 32'd1}, Key2));

    // Reset with a full FIFO clears outputs immediately.
    check_eq("pre_rst_busy", a_busy, 1);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_ksv", a_ksv, 0);
    check_eq("mid_rst_cv", a_cv_o, 0);
    check_eq("mid_rst_busy", a_busy, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("post_rst_cv", a_cv_o, 0);
      check_eq("post_rst_busy", a_busy, 0);
      check_eq("post_rst_ksv", a_ksv, 0);
    end
    a_init = 1'b1;
    @(negedge clk);
    a_init = 1'b0;
    check_eq("post_rst_init_cv", a_cv_o, 1);

    // Re-init with requests in flight, 3-cycle cipher.
    rst = 1'b1;
    a_sel = 2'd2;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    a_ksr = 1'b1; a_nonce = 32'hCAFE_0001; a_key = Key1; a_init = 1'b1;
    @(negedge clk);
    a_init = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("reinit_busy", a_busy, 1);
    a_nonce = 32'hBEEF_0002; a_key = Key2; a_init = 1'b1;
    @(negedge clk);
    a_init = 1'b0;
    check_eq("reinit_empty", a_ksv, 0);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (a_ksv) seen = 1'b1;
      else @(negedge clk);
    end
    check_eq("reinit_seen", seen, 1);
    check_eq("reinit_w0", a_ksd, prince_model({32'hBEEF_0002, 32'd0}, Key2));
    @(negedge clk);
    check_eq("reinit_v1", a_ksv, 1);
    check_eq("reinit_w1", a_ksd, prince_model({32'hBEEF_0002, 32'd1}, Key2));

    // Exhaustion on a 4-bit counter.
    b_nonce = 60'h0123_4567_89AB_CDE; b_key = Key3; b_ksr = 1'b1; b_init = 1'b1;
    @(negedge clk);
    b_init = 1'b0;
    check_eq("exh_start", b_exh, 0);
    words = 0;
    reqs  = 0;
    for (int c = 0; c < 40; c++) begin
      if (b_cv_o) begin
        check_eq("exh_req_d", b_cd_o, {60'h0123_4567_89AB_CDE, 4'(reqs)});
        reqs++;
      end
      if (b_ksv) begin
        check_eq("exh_ks_d", b_ksd, prince_model({60'h0123_4567_89AB_CDE, 4'(words)}, Key3));
        if (words == 15) check_eq("exh_before_last", b_exh, 0);
        words++;
      end
      @(negedge clk);
    end
    check_eq("exh_reqs", reqs, 16);
    check_eq("exh_words", words, 16);
    check_eq("exh_flag", b_exh, 1);
    check_eq("exh_busy", b_busy, 0);
    check_eq("exh_dec", b_dec, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
